// File: rtl/wb_regfile_pkg.sv
// Shared constants, types and read-port selection helper for the write-back register file.
//  N_REG         data width of every GPR, HI and LO
//  N_REG_ADDR    GPR address width; the file holds 2**N_REG_ADDR entries
//  gpr_wr_t      GPR write bundle coming from MEM/WB
//  gpr_read()    read-port priority mux (reset, enable, r0, bypass, storage)
package wb_regfile_pkg;

    localparam int unsigned N_REG      = 32;
    localparam int unsigned N_REG_ADDR = 5;
    localparam int unsigned NUM_REGS   = 2 ** N_REG_ADDR;

    typedef logic [N_REG-1:0]      word_t;
    typedef logic [N_REG_ADDR-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG_ADDR = '0;
    // A stalled MEM/WB bundle targets r0 with write disabled.
    localparam reg_addr_t NOP_REG_ADDR  = ZERO_REG_ADDR;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic RST_ACTIVE    = 1'b1;

    localparam word_t ZERO_WORD = '0;

    typedef struct packed {
        logic      wen;
        reg_addr_t waddr;
        word_t     wdata;
    } gpr_wr_t;

    // Read-port value in priority order: reset, disabled port, r0, same-cycle write, storage.
    function automatic word_t gpr_read(input logic      rst,
                                       input logic      en,
                                       input reg_addr_t addr,
                                       input gpr_wr_t   wr,
                                       input word_t     stored);
        word_t data;
        if (rst == RST_ACTIVE) begin
            data = ZERO_WORD;
        end else if (en == READ_DISABLE) begin
            data = ZERO_WORD;
        end else if (addr == ZERO_REG_ADDR) begin
            data = ZERO_WORD;
        end else if ((wr.wen == WRITE_ENABLE) && (wr.waddr == addr)) begin
            data = wr.wdata;
        end else begin
            data = stored;
        end
        return data;
    endfunction

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// Bus between MEM/WB + ID operand fetch and the write-back register file.
//  i_wb_*     write-back bundle (GPR write and HI/LO write)
//  i_rdN_*    read port N request, o_rdN_data its zero-latency result
//  o_hi/o_lo  current HI/LO including same-cycle bypass
//  master     pipeline side (drives requests), slave: register file
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic      i_wb_wen;
    reg_addr_t i_wb_waddr;
    word_t     i_wb_wdata;
    logic      i_wb_hilo_wen;
    word_t     i_wb_hi;
    word_t     i_wb_lo;
    logic      i_rd1_en;
    reg_addr_t i_rd1_addr;
    word_t     o_rd1_data;
    logic      i_rd2_en;
    reg_addr_t i_rd2_addr;
    word_t     o_rd2_data;
    word_t     o_hi;
    word_t     o_lo;

    modport master (
        output i_wb_wen, i_wb_waddr, i_wb_wdata,
        output i_wb_hilo_wen, i_wb_hi, i_wb_lo,
        output i_rd1_en, i_rd1_addr, i_rd2_en, i_rd2_addr,
        input  o_rd1_data, o_rd2_data, o_hi, o_lo
    );

    modport slave (
        input  i_wb_wen, i_wb_waddr, i_wb_wdata,
        input  i_wb_hilo_wen, i_wb_hi, i_wb_lo,
        input  i_rd1_en, i_rd1_addr, i_rd2_en, i_rd2_addr,
        output o_rd1_data, o_rd2_data, o_hi, o_lo
    );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair with same-cycle write-through bypass.
//  clk_i, rst_i   clock and asynchronous active-high reset
//  wen_i          writes hi_i/lo_i together on the rising edge
//  hi_o, lo_o     bypassed HI/LO, forced to zero while reset is asserted
module hilo_reg
    import wb_regfile_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  wen_i,
    input  word_t hi_i,
    input  word_t lo_i,
    output word_t hi_o,
    output word_t lo_o
);

    word_t hi_q, hi_d;
    word_t lo_q, lo_d;

    // Next state doubles as the bypass value: the pending write if any, else storage.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wen_i == WRITE_ENABLE) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RST_ACTIVE) begin
            hi_q <= ZERO_WORD;
            lo_q <= ZERO_WORD;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        hi_o = hi_d;
        lo_o = lo_d;
        if (rst_i == RST_ACTIVE) begin
            hi_o = ZERO_WORD;
            lo_o = ZERO_WORD;
        end
    end

endmodule : hilo_reg

// File: rtl/wb_regfile.sv
// Write-back register file: commits the MEM/WB bundle into the GPRs and HI/LO, and serves
// two combinational GPR read ports plus the HI/LO read port, all with write-through bypass.
//  i_clk   core clock
//  i_rst   asynchronous active-high reset, clears all state and zeroes all outputs
//  bus     wb_regfile_if slave: write bundle in, read requests in, read data out
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    wb_regfile_if.slave        bus
);

    gpr_wr_t wr;
    word_t   gpr_q [1:NUM_REGS-1];
    word_t   gpr_d [1:NUM_REGS-1];
    word_t   rd1_stored;
    word_t   rd2_stored;

    assign wr = '{wen: bus.i_wb_wen, waddr: bus.i_wb_waddr, wdata: bus.i_wb_wdata};

    // r0 has no storage, so an address-0 write never matches any entry.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            gpr_d[r] = gpr_q[r];
            if ((wr.wen == WRITE_ENABLE) && (wr.waddr == N_REG_ADDR'(r))) begin
                gpr_d[r] = wr.wdata;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst == RST_ACTIVE) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                gpr_q[r] <= ZERO_WORD;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                gpr_q[r] <= gpr_d[r];
            end
        end
    end

    // Storage lookup per read port; address 0 falls through to zero.
    always_comb begin
        rd1_stored = ZERO_WORD;
        rd2_stored = ZERO_WORD;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.i_rd1_addr == N_REG_ADDR'(r)) begin
                rd1_stored = gpr_q[r];
            end
            if (bus.i_rd2_addr == N_REG_ADDR'(r)) begin
                rd2_stored = gpr_q[r];
            end
        end
    end

    assign bus.o_rd1_data = gpr_read(i_rst, bus.i_rd1_en, bus.i_rd1_addr, wr, rd1_stored);
    assign bus.o_rd2_data = gpr_read(i_rst, bus.i_rd2_en, bus.i_rd2_addr, wr, rd2_stored);

    hilo_reg u_hilo_reg (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .wen_i (bus.i_wb_hilo_wen),
        .hi_i  (bus.i_wb_hi),
        .lo_i  (bus.i_wb_lo),
        .hi_o  (bus.o_hi),
        .lo_o  (bus.o_lo)
    );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a driver applies one bundle per cycle and queues the
// outputs a plain array model predicts; a monitor on the falling edge pops and compares.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    typedef struct packed {
        logic      rst;
        logic      wen;
        reg_addr_t waddr;
        word_t     wdata;
        logic      hwen;
        word_t     hi;
        word_t     lo;
        logic      e1;
        reg_addr_t a1;
        logic      e2;
        reg_addr_t a2;
    } stim_t;

    typedef struct {
        word_t rd1;
        word_t rd2;
        word_t hi;
        word_t lo;
    } exp_t;

    logic clk;
    logic rst;
    wb_regfile_if bus ();

    wb_regfile dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: the architectural registers as the pipeline sees them.
    word_t m_gpr [0:31];
    word_t m_hi;
    word_t m_lo;
    exp_t  exp_q [$];
    int    n_err = 0;
    int    n_chk = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.waddr = NOP_REG_ADDR;
        return s;
    endfunction

    function automatic word_t model_rd(input stim_t s, input logic en, input reg_addr_t a);
        if (s.rst) return 32'h0;
        if (!en) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (s.wen && s.waddr == a) return s.wdata;
        return m_gpr[a];
    endfunction

    task automatic check(input string name, input word_t got, input word_t want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Apply one bundle, predict the outputs for this cycle, then advance the model.
    task automatic drive(input stim_t s);
        exp_t e;
        rst               = s.rst;
        bus.i_wb_wen      = s.wen;
        bus.i_wb_waddr    = s.waddr;
        bus.i_wb_wdata    = s.wdata;
        bus.i_wb_hilo_wen = s.hwen;
        bus.i_wb_hi       = s.hi;
        bus.i_wb_lo       = s.lo;
        bus.i_rd1_en      = s.e1;
        bus.i_rd1_addr    = s.a1;
        bus.i_rd2_en      = s.e2;
        bus.i_rd2_addr    = s.a2;
        e.rd1 = model_rd(s, s.e1, s.a1);
        e.rd2 = model_rd(s, s.e2, s.a2);
        e.hi  = s.rst ? 32'h0 : (s.hwen ? s.hi : m_hi);
        e.lo  = s.rst ? 32'h0 : (s.hwen ? s.lo : m_lo);
        exp_q.push_back(e);
        if (s.rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (s.wen && s.waddr != 5'd0) m_gpr[s.waddr] = s.wdata;
            if (s.hwen) begin
                m_hi = s.hi;
                m_lo = s.lo;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd1", bus.o_rd1_data, e.rd1);
            check("rd2", bus.o_rd2_data, e.rd2);
            check("hi", bus.o_hi, e.hi);
            check("lo", bus.o_lo, e.lo);
        end
    end

    function automatic reg_addr_t rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        stim_t s;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        s = idle();
        s.rst = 1'b1;
        rst = 1'b1;
        bus.i_wb_wen = 1'b0;   bus.i_wb_waddr = '0;   bus.i_wb_wdata = '0;
        bus.i_wb_hilo_wen = 1'b0; bus.i_wb_hi = '0;   bus.i_wb_lo = '0;
        bus.i_rd1_en = 1'b0;   bus.i_rd1_addr = '0;
        bus.i_rd2_en = 1'b0;   bus.i_rd2_addr = '0;
        @(posedge clk);
        #1;

        // Reset state, with live inputs that must be ignored.
        s = idle(); s.rst = 1'b1; s.wen = 1'b1; s.waddr = 5'd3; s.wdata = 32'hCAFE0003;
        s.hwen = 1'b1; s.hi = 32'h77; s.lo = 32'h88; s.e1 = 1'b1; s.a1 = 5'd3; s.e2 = 1'b1; s.a2 = 5'd4;
        drive(s);
        drive(s);

        // Seed r5 and HI/LO, then reset mid-run during a write to r5.
        s = idle(); s.wen = 1'b1; s.waddr = 5'd5; s.wdata = 32'h11111111;
        s.hwen = 1'b1; s.hi = 32'hAAAA0001; s.lo = 32'hBBBB0002;
        drive(s);
        s = idle(); s.e1 = 1'b1; s.a1 = 5'd5;
        drive(s);
        s = idle(); s.rst = 1'b1; s.wen = 1'b1; s.waddr = 5'd5; s.wdata = 32'hDEADBEEF;
        s.e1 = 1'b1; s.a1 = 5'd5;
        drive(s);
        s = idle(); s.e1 = 1'b1; s.a1 = 5'd5;
        drive(s);

        // Write r7, read it back, then read with the port disabled.
        s = idle(); s.wen = 1'b1; s.waddr = 5'd7; s.wdata = 32'h12345678;
        drive(s);
        s = idle(); s.e1 = 1'b1; s.a1 = 5'd7;
        drive(s);
        s.e1 = 1'b0;
        drive(s);

        // Bypass to both ports, then stored value.
        s = idle(); s.wen = 1'b1; s.waddr = 5'd9; s.wdata = 32'hA5A5A5A5;
        s.e1 = 1'b1; s.a1 = 5'd9; s.e2 = 1'b1; s.a2 = 5'd9;
        drive(s);
        s.wen = 1'b0; s.wdata = 32'h0;
        drive(s);

        // r0 stays zero, including through the bypass path.
        s = idle(); s.wen = 1'b1; s.waddr = 5'd0; s.wdata = 32'hFFFFFFFF;
        s.e1 = 1'b1; s.a1 = 5'd0; s.e2 = 1'b1; s.a2 = 5'd0;
        drive(s);
        s.wen = 1'b0;
        drive(s);

        // HI/LO bypass and hold, with a concurrent GPR write to r3.
        s = idle(); s.hwen = 1'b1; s.hi = 32'h1; s.lo = 32'h2;
        s.wen = 1'b1; s.waddr = 5'd3; s.wdata = 32'h33330003;
        drive(s);
        s = idle(); s.hi = 32'h9; s.lo = 32'h8; s.e1 = 1'b1; s.a1 = 5'd3;
        drive(s);

        // NOP bundles, then a full scan of the file.
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.wdata = 32'h55; s.e1 = 1'b1; s.a1 = 5'd7;
            drive(s);
        end
        for (int i = 0; i < 16; i++) begin
            s = idle(); s.e1 = 1'b1; s.a1 = 5'(2 * i); s.e2 = 1'b1; s.a2 = 5'(2 * i + 1);
            drive(s);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst   = ($urandom_range(0, 63) == 0);
            s.wen   = 1'($urandom_range(0, 1));
            s.waddr = rnd_addr();
            s.wdata = $urandom();
            s.hwen  = ($urandom_range(0, 3) == 0);
            s.hi    = $urandom();
            s.lo    = $urandom();
            s.e1    = ($urandom_range(0, 7) != 0);
            s.a1    = rnd_addr();
            s.e2    = ($urandom_range(0, 7) != 0);
            s.a2    = rnd_addr();
            drive(s);
        end

        s = idle();
        rst = 1'b0;
        bus.i_wb_wen = 1'b0;
        bus.i_wb_hilo_wen = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            n_chk++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_wb_regfile
